// File: rtl/alu_operand_fetch.sv
// Purpose : operand-fetch stage ahead of the 36-bit ALU. It holds the register file and a
//           per-register busy scoreboard, and issues a registered operand pair with its opcode.
// Latency : operands appear on o_a/o_b one cycle after an issue is accepted.
// Backpressure: while o_valid && !i_ready all outputs hold and no issue is accepted.
//               Hazards on rs1/rs2/rd also deassert o_issue_ready.
//
// Ports:
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_issue_valid       upstream instruction valid
//   o_issue_ready       instruction can be taken this cycle (independent of i_issue_valid)
//   i_rs1, i_rs2, i_rd  source and destination register addresses
//   i_ALUControlS       opcode (00 ADD, 01 SUB, 10 AND, 11 OR), carried through unmodified
//   i_wb_en/addr/data   write-back port; its data is bypassed into same-cycle reads
//   o_valid, i_ready    valid/ready handshake towards the ALU
//   o_a, o_b            operands for the ALU
//   o_ALUControlS       opcode for the ALU
//   o_rd                destination tag that travels with the bundle
module alu_operand_fetch #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_issue_valid,
  output logic                  o_issue_ready,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic [1:0]            i_ALUControlS,
  input  logic                  i_wb_en,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [1:0]            o_ALUControlS,
  output logic [ADDR_WIDTH-1:0] o_rd
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Architectural state
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;

  // Read / bypass / hazard terms
  logic                  wb_hit_rs1;
  logic                  wb_hit_rs2;
  logic                  wb_hit_rd;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic                  haz_rs1;
  logic                  haz_rs2;
  logic                  haz_rd;
  logic                  hazard;
  logic                  out_free;
  logic                  accept;

  // A write-back to the same register in this cycle supplies its data and also
  // resolves any pending busy state for that register.
  assign wb_hit_rs1 = i_wb_en && (i_wb_addr == i_rs1);
  assign wb_hit_rs2 = i_wb_en && (i_wb_addr == i_rs2);
  assign wb_hit_rd  = i_wb_en && (i_wb_addr == i_rd);

  always_comb begin
    rs1_val = regs[i_rs1];
    if (i_rs1 == '0) begin
      rs1_val = '0;
    end else if (wb_hit_rs1) begin
      rs1_val = i_wb_data;
    end
  end

  always_comb begin
    rs2_val = regs[i_rs2];
    if (i_rs2 == '0) begin
      rs2_val = '0;
    end else if (wb_hit_rs2) begin
      rs2_val = i_wb_data;
    end
  end

  assign haz_rs1 = (i_rs1 != '0) && busy[i_rs1] && !wb_hit_rs1;
  assign haz_rs2 = (i_rs2 != '0) && busy[i_rs2] && !wb_hit_rs2;
  // WAW: do not re-target a register whose earlier result is still outstanding.
  assign haz_rd  = (i_rd  != '0) && busy[i_rd]  && !wb_hit_rd;
  assign hazard  = haz_rs1 || haz_rs2 || haz_rd;

  // The output register can take a new bundle if it is empty or being drained now.
  assign out_free      = !o_valid || i_ready;
  assign o_issue_ready = !hazard && out_free;
  assign accept        = i_issue_valid && o_issue_ready;

  // Busy scoreboard next state: the write-back clear is applied first so that an
  // issue targeting the same register in the same cycle leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (i_wb_en) begin
      busy_nxt[i_wb_addr] = 1'b0;
    end
    if (accept && (i_rd != '0)) begin
      busy_nxt[i_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Register file; register 0 is never written and so stays zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (i_wb_en && (i_wb_addr != '0)) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Output bundle register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_a           <= '0;
      o_b           <= '0;
      o_ALUControlS <= 2'b00;
      o_rd          <= '0;
    end else if (accept) begin
      o_valid       <= 1'b1;
      o_a           <= rs1_val;
      o_b           <= rs2_val;
      o_ALUControlS <= i_ALUControlS;
      o_rd          <= i_rd;
    end else if (o_valid && i_ready) begin
      // Drain: the bundle was taken and nothing replaces it; data fields keep their values.
      o_valid <= 1'b0;
    end
  end

endmodule
